coax_rx_ctrl: RTL and testbench
===============================

// Module: coax_rx_ctrl
// PURPOSE
// - Sequences the coax receiver: gates it by rx_enable, delimits frames, resets it after errors and times out missing responses.
// - Packs received 10-bit words into 16-bit tagged words for the host receive FIFO.
// - Sits between the coax receiver and the receive FIFO; rx_enable and rx_expect come from the transmit side.
// PARAMETERS
// - RESET_CLOCKS    2     cycles rx_reset is held after an error or on disable
// - TIMEOUT_CLOCKS  2000  cycles after rx_expect before a timeout word is emitted; 0 disables timeout
// PORTS
// - clk          in   1   system clock
// - reset        in   1   asynchronous, active-high reset
// - rx_enable    in   1   1 = receive allowed; 0 = receiver held in reset
// - rx_expect    in   1   1-cycle pulse: transmit done, response expected
// - rx_active    in   1   receiver active (from coax receiver)
// - rx_error     in   1   receiver in error state; rx_data holds the error code
// - rx_data      in   10  receiver data or error code
// - rx_strobe    in   1   1-cycle pulse: rx_data holds a valid word
// - rx_reset     out  1   synchronous reset to the coax receiver
// - fifo_data    out  16  {ERR, EOF, 4'b0, data[9:0]}
// - fifo_write   out  1   1-cycle write pulse
// - fifo_full    in   1   FIFO cannot accept a write this cycle
// - overflow     out  1   sticky: a word was dropped because the FIFO was full
// - busy         out  1   state is RECEIVING or ERROR_HOLD
// BEHAVIOUR
// - Reset values: rx_reset=1, fifo_data=0, fifo_write=0, overflow=0, busy=0; state=DISABLED, pending empty.
// - All outputs are registered; each fifo_write occurs exactly 1 cycle after its triggering input.
// - States: DISABLED, IDLE, WAIT_RESPONSE, RECEIVING, ERROR_HOLD.
// - DISABLED:
//   - rx_reset=1.
//   - When rx_enable=1, go to IDLE and drop rx_reset.
//   - overflow clears while rx_enable=0.
// - rx_enable=0 in any state:
//   - Next state is DISABLED; pending word discarded, no write, timer cleared.
//   - This takes priority over all other events.
// - IDLE:
//   - rx_expect=1 -> WAIT_RESPONSE; timer loaded with TIMEOUT_CLOCKS.
//   - rx_active rising -> RECEIVING.
// - WAIT_RESPONSE:
//   - Timer decrements each cycle.
//   - rx_active rising -> RECEIVING; timer cleared.
//   - Timer reaches 0 -> write 16'hC008 (ERR, EOF, code 10'h008), go to IDLE.
//   - rx_active rising on the same cycle the timer reaches 0: the rising edge wins, no timeout word.
//   - rx_expect re-pulse reloads the timer.
// - RECEIVING, one-word holding register ("pending"), so EOF marks the last word:
//   - rx_strobe with pending empty: latch rx_data; no write.
//   - rx_strobe with pending full: write {2'b00, 4'b0, pending}, then latch rx_data.
//   - rx_active falling with pending full: write {0, 1, 4'b0, pending}, go to IDLE.
//   - rx_active falling with pending empty: no write, go to IDLE.
//   - rx_error:
//     - Pending full: write pending with EOF=0, then 1 cycle later write {1, 1, 4'b0, rx_data}.
//     - Pending empty: write only the error word.
//     - Then ERROR_HOLD.
// - ERROR_HOLD:
//   - rx_reset=1 for RESET_CLOCKS cycles, then IDLE.
//   - rx_strobe and rx_active are ignored.
// - Edge priority: rx_strobe and rx_active falling in the same cycle -> strobe processed first; EOF write 1 cycle after the data write.
// - Full FIFO:
//   - A write attempted while fifo_full=1 is dropped (fifo_write stays 0) and overflow is set.
//   - The FSM does not stall.
// - Edges on rx_active are detected against a registered copy of rx_active.
// - The timer is $clog2(TIMEOUT_CLOCKS+1) bits, saturates at 0 and never wraps.
// CONFIGURATION
// - COAX_RX_CTRL_STATS_EN defined adds outputs:
//   - frame_count[15:0]: increments on each EOF write with ERR=0; wraps.
//   - error_count[7:0]: increments on each ERR write (including timeout); saturates at 8'hFF.
//   - Both reset to 0 and are cleared while rx_enable=0.
// - COAX_RX_CTRL_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
// - reset release, rx_enable=0 -> rx_reset=1, no fifo_write; rx_enable=1 -> rx_reset=0 next cycle, state IDLE.
// - frame of 3 strobes 10'h2A5, 10'h001, 10'h3FF, then rx_active falls -> writes 16'h02A5, 16'h0001, 16'h43FF; overflow=0.
// - strobe 10'h155, then rx_error with code 10'h002 -> writes 16'h0155, 16'hC002; rx_reset high 2 cycles; back to IDLE.
// - TIMEOUT_CLOCKS=16: rx_expect, no activity -> 16'hC008 written; rx_active rise at cycle 10 -> no timeout word.
// - fifo_full=1 during 2nd word of 3-word frame -> that word dropped, overflow=1 until rx_enable=0.
// - rx_enable=0 mid-frame with pending word -> no write, rx_reset=1, state DISABLED; STATS_EN: frame_count unchanged.

Source files
------------

// File: rtl/coax_rx_ctrl.sv
// Coax receive sequencer: gates the receiver, delimits frames, recovers from errors and times out responses.
// Optional COAX_RX_CTRL_STATS_EN adds frame_count / error_count statistics outputs.
module coax_rx_ctrl #(
    parameter int unsigned RESET_CLOCKS   = 2,
    parameter int unsigned TIMEOUT_CLOCKS = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_enable,
    input  logic        rx_expect,
    input  logic        rx_active,
    input  logic        rx_error,
    input  logic [9:0]  rx_data,
    input  logic        rx_strobe,
    output logic        rx_reset,
    output logic [15:0] fifo_data,
    output logic        fifo_write,
    input  logic        fifo_full,
    output logic        overflow,
`ifdef COAX_RX_CTRL_STATS_EN
    output logic [15:0] frame_count,
    output logic [7:0]  error_count,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {
        DISABLED,
        IDLE,
        WAIT_RESPONSE,
        RECEIVING,
        ERROR_HOLD
    } state_t;

    localparam int unsigned TW = (TIMEOUT_CLOCKS > 0) ? $clog2(TIMEOUT_CLOCKS + 1) : 1;
    localparam int unsigned HW = (RESET_CLOCKS > 1) ? $clog2(RESET_CLOCKS) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CLOCKS);
    localparam logic [HW-1:0] H_LOAD = (RESET_CLOCKS > 0) ? HW'(RESET_CLOCKS - 1) : HW'(0);
    localparam logic [15:0] TIMEOUT_WORD = 16'hC008;

    state_t          state, state_n;
    logic            act_q;
    logic            pend_v, pend_v_n;
    logic [9:0]      pend_d, pend_d_n;
    logic            def_v, def_v_n;
    logic [15:0]     def_d, def_d_n;
    logic [TW-1:0]   timer, timer_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic            wr_req;
    logic [15:0]     wr_data;
    logic            rise, fall;
    logic            last_v;
    logic [9:0]      last_d;

    logic            fifo_write_n, overflow_n, rx_reset_n, busy_n;
    logic [15:0]     fifo_data_n;
`ifdef COAX_RX_CTRL_STATS_EN
    logic [15:0]     frame_count_n;
    logic [7:0]      error_count_n;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DISABLED;
        end else begin
            state <= state_n;
        end
    end

    // A second write in one cycle (pending + EOF/error) is deferred to the next
    // cycle; the FSM is then in IDLE or ERROR_HOLD, which never write themselves.
    always_comb begin
        rise     = rx_active & ~act_q;
        fall     = ~rx_active & act_q;
        state_n  = state;
        pend_v_n = pend_v;
        pend_d_n = pend_d;
        def_v_n  = 1'b0;
        def_d_n  = def_d;
        timer_n  = timer;
        hold_n   = hold_cnt;
        wr_req   = def_v;
        wr_data  = def_d;
        last_v   = rx_strobe | pend_v;
        last_d   = rx_strobe ? rx_data : pend_d;

        case (state)
            DISABLED: begin
                if (rx_enable) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_n = RECEIVING;
                end else if (rx_expect) begin
                    state_n = WAIT_RESPONSE;
                    timer_n = T_LOAD;
                end
            end
            WAIT_RESPONSE: begin
                if (rise) begin
                    state_n = RECEIVING;
                    timer_n = '0;
                end else if (rx_expect) begin
                    timer_n = T_LOAD;
                end else if (TIMEOUT_CLOCKS != 0 && timer <= TW'(1)) begin
                    wr_req  = 1'b1;
                    wr_data = TIMEOUT_WORD;
                    timer_n = '0;
                    state_n = IDLE;
                end else if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end
            end
            RECEIVING: begin
                if (rx_error) begin
                    state_n  = ERROR_HOLD;
                    hold_n   = H_LOAD;
                    pend_v_n = 1'b0;
                    wr_req   = 1'b1;
                    if (pend_v) begin
                        wr_data = {6'b0, pend_d};
                        def_v_n = 1'b1;
                        def_d_n = {2'b11, 4'b0, rx_data};
                    end else begin
                        wr_data = {2'b11, 4'b0, rx_data};
                    end
                end else begin
                    if (rx_strobe) begin
                        if (pend_v) begin
                            wr_req  = 1'b1;
                            wr_data = {6'b0, pend_d};
                        end
                        pend_v_n = 1'b1;
                        pend_d_n = rx_data;
                    end
                    // Strobe is folded in first, so a same-cycle fall closes on the new word.
                    if (fall) begin
                        state_n  = IDLE;
                        pend_v_n = 1'b0;
                        if (last_v) begin
                            if (rx_strobe && pend_v) begin
                                def_v_n = 1'b1;
                                def_d_n = {2'b01, 4'b0, last_d};
                            end else begin
                                wr_req  = 1'b1;
                                wr_data = {2'b01, 4'b0, last_d};
                            end
                        end
                    end
                end
            end
            ERROR_HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    hold_n = hold_cnt - HW'(1);
                end
            end
            default: begin
                state_n = DISABLED;
            end
        endcase

        if (!rx_enable) begin
            state_n  = DISABLED;
            pend_v_n = 1'b0;
            def_v_n  = 1'b0;
            wr_req   = 1'b0;
            timer_n  = '0;
        end
    end

    always_comb begin
        fifo_write_n = wr_req & ~fifo_full;
        fifo_data_n  = fifo_write_n ? wr_data : fifo_data;
        overflow_n   = rx_enable & (overflow | (wr_req & fifo_full));
        rx_reset_n   = (state_n == DISABLED) || (state_n == ERROR_HOLD);
        busy_n       = (state_n == RECEIVING) || (state_n == ERROR_HOLD);
`ifdef COAX_RX_CTRL_STATS_EN
        frame_count_n = frame_count;
        error_count_n = error_count;
        if (!rx_enable) begin
            frame_count_n = '0;
            error_count_n = '0;
        end else if (fifo_write_n) begin
            if (wr_data[15]) begin
                if (error_count != '1) begin
                    error_count_n = error_count + 8'd1;
                end
            end else if (wr_data[14]) begin
                frame_count_n = frame_count + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q      <= 1'b0;
            pend_v     <= 1'b0;
            pend_d     <= '0;
            def_v      <= 1'b0;
            def_d      <= '0;
            timer      <= '0;
            hold_cnt   <= '0;
            fifo_write <= 1'b0;
            fifo_data  <= '0;
            overflow   <= 1'b0;
            rx_reset   <= 1'b1;
            busy       <= 1'b0;
`ifdef COAX_RX_CTRL_STATS_EN
            frame_count <= '0;
            error_count <= '0;
`endif
        end else begin
            act_q      <= rx_active;
            pend_v     <= pend_v_n;
            pend_d     <= pend_d_n;
            def_v      <= def_v_n;
            def_d      <= def_d_n;
            timer      <= timer_n;
            hold_cnt   <= hold_n;
            fifo_write <= fifo_write_n;
            fifo_data  <= fifo_data_n;
            overflow   <= overflow_n;
            rx_reset   <= rx_reset_n;
            busy       <= busy_n;
`ifdef COAX_RX_CTRL_STATS_EN
            frame_count <= frame_count_n;
            error_count <= error_count_n;
`endif
        end
    end

endmodule

// File: tb/tb_coax_rx_ctrl.sv
// Bench for coax_rx_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of frames, deadlines and hold windows.
module tb_coax_rx_ctrl;
    localparam int unsigned RC = 2;
    localparam int unsigned TC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_enable, rx_expect, rx_active, rx_error, rx_strobe, fifo_full;
    logic [9:0]  rx_data;
    logic        rx_reset, fifo_write, overflow, busy;
    logic [15:0] fifo_data;

    coax_rx_ctrl #(.RESET_CLOCKS(RC), .TIMEOUT_CLOCKS(TC)) dut (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .rx_expect(rx_expect),
        .rx_active(rx_active), .rx_error(rx_error), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .rx_reset(rx_reset), .fifo_data(fifo_data), .fifo_write(fifo_write),
        .fifo_full(fifo_full), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flags for enabled / in-frame / holding, absolute-edge deadlines,
    // a one-word holding slot and a list of words owed to the FIFO.
    bit          m_en, m_recv, m_hold, m_pv, m_ovf, m_act_prev, exp_wr, rise, fall;
    int          m_edge, m_hold_end, m_deadline;
    logic [9:0]  m_pd;
    logic [15:0] exp_data;
    logic [15:0] later_q[$];
    logic [15:0] wl[$];
    logic [15:0] cap_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_en = 0; m_recv = 0; m_hold = 0; m_pv = 0; m_ovf = 0; m_act_prev = 0;
            m_edge = 0; m_deadline = -1; m_hold_end = 0;
            later_q = {};
        end else begin
            m_edge++;
            wl = later_q;
            later_q = {};
            rise = rx_active && !m_act_prev;
            fall = !rx_active && m_act_prev;
            if (!rx_enable) begin
                m_en = 0; m_recv = 0; m_hold = 0; m_pv = 0; m_ovf = 0;
                m_deadline = -1;
                wl = {};
            end else if (!m_en) begin
                m_en = 1;
            end else if (m_hold) begin
                if (m_edge >= m_hold_end) m_hold = 0;
            end else if (m_recv) begin
                if (rx_error) begin
                    if (m_pv) wl.push_back({6'b0, m_pd});
                    wl.push_back({6'b110000, rx_data});
                    m_pv = 0; m_recv = 0; m_hold = 1; m_hold_end = m_edge + RC;
                end else begin
                    if (rx_strobe) begin
                        if (m_pv) wl.push_back({6'b0, m_pd});
                        m_pv = 1; m_pd = rx_data;
                    end
                    if (fall) begin
                        if (m_pv) wl.push_back({6'b010000, m_pd});
                        m_pv = 0; m_recv = 0;
                    end
                end
            end else begin
                if (rise) begin
                    m_recv = 1; m_deadline = -1;
                end else if (rx_expect) begin
                    m_deadline = m_edge + TC;
                end else if (m_deadline == m_edge) begin
                    wl.push_back(16'hC008);
                    m_deadline = -1;
                end
            end
            exp_wr = 0;
            if (wl.size() > 0) begin
                if (fifo_full) m_ovf = 1;
                else begin exp_wr = 1; exp_data = wl[0]; end
                for (int i = 1; i < wl.size(); i++) later_q.push_back(wl[i]);
            end
            m_act_prev = rx_active;
            #1;
            chk("fifo_write", {15'b0, fifo_write}, {15'b0, exp_wr});
            if (exp_wr) chk("fifo_data", fifo_data, exp_data);
            chk("overflow", {15'b0, overflow}, {15'b0, m_ovf});
            chk("rx_reset", {15'b0, rx_reset}, {15'b0, (!m_en || m_hold)});
            chk("busy", {15'b0, busy}, {15'b0, (m_recv || m_hold)});
            if (fifo_write) cap_q.push_back(fifo_data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [9:0] d);
        rx_data = d; rx_strobe = 1; tick(); rx_strobe = 0;
    endtask

    task automatic chk_cap(input string name, input int idx, input logic [15:0] exp);
        logic [15:0] v;
        v = (idx < cap_q.size()) ? cap_q[idx] : 16'hxxxx;
        chk(name, v, exp);
    endtask

    int n_rst;
    int dis_left;

    initial begin
        reset = 1; rx_enable = 0; rx_expect = 0; rx_active = 0; rx_error = 0;
        rx_strobe = 0; fifo_full = 0; rx_data = '0;
        tick(3);
        chk("reset rx_reset", {15'b0, rx_reset}, 16'd1);
        chk("reset fifo_write", {15'b0, fifo_write}, 16'd0);
        chk("reset fifo_data", fifo_data, 16'h0000);
        chk("reset overflow", {15'b0, overflow}, 16'd0);
        chk("reset busy", {15'b0, busy}, 16'd0);
        reset = 0;
        tick(3);
        chk("disabled rx_reset", {15'b0, rx_reset}, 16'd1);
        chk("disabled no writes", 16'(cap_q.size()), 16'd0);
        rx_enable = 1;
        tick();
        chk("enable rx_reset", {15'b0, rx_reset}, 16'd0);

        // 3-word frame
        cap_q.delete();
        rx_active = 1; tick(2);
        strobe(10'h2A5); tick(); strobe(10'h001); tick(); strobe(10'h3FF); tick();
        rx_active = 0; tick(3);
        chk("frame count", 16'(cap_q.size()), 16'd3);
        chk_cap("frame w0", 0, 16'h02A5);
        chk_cap("frame w1", 1, 16'h0001);
        chk_cap("frame w2", 2, 16'h43FF);
        chk("frame overflow", {15'b0, overflow}, 16'd0);

        // error with a pending word
        cap_q.delete();
        rx_active = 1; tick(2);
        strobe(10'h155); tick();
        rx_data = 10'h002; rx_error = 1; tick(); rx_error = 0;
        n_rst = 0;
        for (int i = 0; i < 5; i++) begin
            if (rx_reset) n_rst++;
            tick();
        end
        chk("error hold cycles", 16'(n_rst), 16'(RC));
        chk("error back idle", {15'b0, busy}, 16'd0);
        rx_active = 0; tick(2);
        chk("error count", 16'(cap_q.size()), 16'd2);
        chk_cap("error w0", 0, 16'h0155);
        chk_cap("error w1", 1, 16'hC002);

        // timeout, then a response that arrives in time
        cap_q.delete();
        rx_expect = 1; tick(); rx_expect = 0;
        tick(TC + 3);
        chk("timeout count", 16'(cap_q.size()), 16'd1);
        chk_cap("timeout word", 0, 16'hC008);
        cap_q.delete();
        rx_expect = 1; tick(); rx_expect = 0;
        tick(9);
        rx_active = 1; tick(TC + 5);
        chk("late rise no word", 16'(cap_q.size()), 16'd0);
        chk("late rise busy", {15'b0, busy}, 16'd1);
        rx_active = 0; tick(2);

        // FIFO full while the 2nd word is written
        cap_q.delete();
        rx_active = 1; tick(2);
        strobe(10'h011); tick(); strobe(10'h022); tick();
        fifo_full = 1; strobe(10'h033); fifo_full = 0; tick();
        rx_active = 0; tick(3);
        chk("full count", 16'(cap_q.size()), 16'd2);
        chk_cap("full w0", 0, 16'h0011);
        chk_cap("full w1", 1, 16'h4033);
        tick(5);
        chk("overflow sticky", {15'b0, overflow}, 16'd1);
        rx_enable = 0; tick();
        chk("overflow cleared", {15'b0, overflow}, 16'd0);
        rx_enable = 1; tick(2);

        // disable mid-frame with a pending word
        cap_q.delete();
        rx_active = 1; tick(2);
        strobe(10'h0AA); tick();
        rx_enable = 0; tick();
        chk("disable rx_reset", {15'b0, rx_reset}, 16'd1);
        chk("disable busy", {15'b0, busy}, 16'd0);
        tick(2);
        chk("disable no write", 16'(cap_q.size()), 16'd0);
        rx_active = 0; rx_enable = 1; tick(2);

        // randomized traffic
        dis_left = 0;
        for (int i = 0; i < 4000; i++) begin
            rx_expect = ($urandom_range(0, 39) == 0);
            rx_error  = ($urandom_range(0, 59) == 0);
            rx_strobe = rx_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            rx_data   = 10'($urandom);
            fifo_full = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 11) == 0) rx_active = ~rx_active;
            if (dis_left > 0) begin
                dis_left--;
                rx_enable = (dis_left == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                rx_enable = 0;
                dis_left = $urandom_range(1, 5);
            end
            tick();
        end
        rx_expect = 0; rx_error = 0; rx_strobe = 0; fifo_full = 0; rx_enable = 1;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
